// File: rtl/status_uart_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : status_uart_tx_pkg
//  Description : Shared types, ASCII constants and formatting helpers for the
//                status-line UART transmitter.
//  Revision    : 1.0 - initial release
// ============================================================================
package status_uart_tx_pkg;

    // Number of bytes in one status line: "S" hh " " "P" hhhh CR LF
    localparam int MSG_LEN = 11;

    localparam logic [7:0] CH_S  = 8'h53;
    localparam logic [7:0] CH_P  = 8'h50;
    localparam logic [7:0] CH_SP = 8'h20;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;

    // Bit-level serializer states (FIN marks the one-cycle end-of-line slot)
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        FIN   = 3'd4
    } tx_state_t;

    // Line-level sequencing states used by the top level
    typedef enum logic [1:0] {
        LN_IDLE = 2'd0,
        LN_RUN  = 2'd1,
        LN_FIN  = 2'd2
    } line_state_t;

    // One nibble to its uppercase ASCII hex digit
    function automatic logic [7:0] hex_ascii(input logic [3:0] d);
        logic [7:0] c;
        if (d < 4'd10) begin
            c = 8'h30 + {4'h0, d};
        end else begin
            c = 8'h37 + {4'h0, d};
        end
        return c;
    endfunction

    // Byte at position idx of the status line for the given snapshot
    function automatic logic [7:0] msg_char(input logic [3:0]  idx,
                                            input logic [7:0]  st,
                                            input logic [15:0] sc);
        logic [7:0] c;
        c = CH_LF;
        case (idx)
            4'd0:    c = CH_S;
            4'd1:    c = hex_ascii(st[7:4]);
            4'd2:    c = hex_ascii(st[3:0]);
            4'd3:    c = CH_SP;
            4'd4:    c = CH_P;
            4'd5:    c = hex_ascii(sc[15:12]);
            4'd6:    c = hex_ascii(sc[11:8]);
            4'd7:    c = hex_ascii(sc[7:4]);
            4'd8:    c = hex_ascii(sc[3:0]);
            4'd9:    c = CH_CR;
            default: c = CH_LF;
        endcase
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/status_uart_tx_byte.sv
`default_nettype none
// ============================================================================
//  Module      : uart_byte_tx
//  Description : 8N1 byte serializer, LSB first, with valid/ready handshake.
//                Ready is raised in IDLE and in the last cycle of the stop bit
//                so a following byte starts with no idle gap.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_byte_tx
    import status_uart_tx_pkg::*;
#(
    parameter int DIV = 434
) (
    input  logic       clk,
    input  logic       i_rst_n,
    input  logic       i_valid,
    input  logic [7:0] i_data,
    output logic       o_ready,
    output logic       o_tx
);

    localparam int                 CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DIV - 1);

    tx_state_t        r_state;
    tx_state_t        w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             r_tx;
    logic             w_bit_end;
    logic             w_accept;

    assign w_bit_end = (r_cnt == CNT_LAST);
    assign o_ready   = (r_state == IDLE) || ((r_state == STOP) && w_bit_end);
    assign w_accept  = i_valid && o_ready;
    assign o_tx      = r_tx;

    // Next-state logic: each bit lasts exactly DIV cycles
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = START;
            START:   if (w_bit_end) w_next = DATA;
            DATA:    if (w_bit_end && (r_bit_idx == 3'd7)) w_next = STOP;
            STOP:    if (w_bit_end) w_next = w_accept ? START : IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Baud counter: free-runs inside a frame, wraps at the end of every bit
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if ((r_state == IDLE) || w_bit_end) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Shift register and serial line; the line drives the next bit at each bit end
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tx      <= 1'b1;
            r_shift   <= 8'h00;
            r_bit_idx <= 3'd0;
        end else if (w_accept) begin
            r_tx      <= 1'b0;
            r_shift   <= i_data;
            r_bit_idx <= 3'd0;
        end else if ((r_state != IDLE) && w_bit_end) begin
            case (r_state)
                START: begin
                    r_tx    <= r_shift[0];
                    r_shift <= {1'b0, r_shift[7:1]};
                end
                DATA: begin
                    if (r_bit_idx == 3'd7) begin
                        r_tx <= 1'b1;
                    end else begin
                        r_tx      <= r_shift[0];
                        r_shift   <= {1'b0, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                    end
                end
                default: r_tx <= 1'b1;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/status_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : status_uart_tx
//  Description : Snapshots game state/score on request and transmits the line
//                "S<hh> P<hhhh>\r\n" over an 8N1 UART. Handles a one-deep
//                pending request so back-to-back lines are 1 cycle apart.
//  Revision    : 1.0 - initial release
// ============================================================================
module status_uart_tx
    import status_uart_tx_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115200
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  state,
    input  logic [15:0] score,
    input  logic        send,
    output logic        busy,
    output logic        done,
    output logic        uart_tx
);

    localparam int         DIV      = CLK_HZ / BAUD;
    localparam logic [3:0] LAST_IDX = 4'(MSG_LEN - 1);

    line_state_t r_state;
    line_state_t w_next;
    logic [3:0]  r_byte_idx;
    logic [7:0]  r_snap_state;
    logic [15:0] r_snap_score;
    logic        r_pending;
    logic        w_go;
    logic        w_valid;
    logic [7:0]  w_data;
    logic        w_ready;
    logic        w_accept;

    assign w_accept = w_valid && w_ready;
    assign done     = (r_state == LN_FIN);
    assign busy     = (r_state == LN_RUN) || ((r_state == LN_FIN) && w_go);

    // Line sequencing: start a line, feed bytes on each handshake, end in FIN
    always_comb begin
        w_next  = r_state;
        w_go    = 1'b0;
        w_valid = 1'b0;
        w_data  = CH_S;
        case (r_state)
            LN_IDLE: begin
                w_go    = send;
                w_valid = send;
                if (send) w_next = LN_RUN;
            end
            LN_RUN: begin
                w_valid = (r_byte_idx < LAST_IDX);
                w_data  = msg_char(r_byte_idx + 4'd1, r_snap_state, r_snap_score);
                if (w_ready && (r_byte_idx == LAST_IDX)) w_next = LN_FIN;
            end
            LN_FIN: begin
                // A request arriving on this very cycle counts as pending
                w_go    = r_pending || send;
                w_valid = w_go;
                w_next  = w_go ? LN_RUN : LN_IDLE;
            end
            default: w_next = LN_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= LN_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Snapshot of the inputs taken when a line is launched
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_snap_state <= 8'h00;
            r_snap_score <= 16'h0000;
        end else if (w_go) begin
            r_snap_state <= state;
            r_snap_score <= score;
        end
    end

    // Index of the byte currently on the wire; never passes the last byte
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_byte_idx <= 4'd0;
        end else if (w_go) begin
            r_byte_idx <= 4'd0;
        end else if ((r_state == LN_RUN) && w_accept) begin
            r_byte_idx <= r_byte_idx + 4'd1;
        end
    end

    // One-deep pending request; consumed (or dropped) at the end of each line
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pending <= 1'b0;
        end else if (r_state == LN_FIN) begin
            r_pending <= 1'b0;
        end else if ((r_state == LN_RUN) && send) begin
            r_pending <= 1'b1;
        end
    end

    uart_byte_tx #(
        .DIV (DIV)
    ) u_byte_tx (
        .clk     (clk),
        .i_rst_n (reset_n),
        .i_valid (w_valid),
        .i_data  (w_data),
        .o_ready (w_ready),
        .o_tx    (uart_tx)
    );

endmodule
`default_nettype wire

// File: tb/tb_status_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_status_uart_tx
//  Description : Scoreboard bench for status_uart_tx at DIV=10. Stimulus
//                pushes expected bytes and done-pulse cycles; a monitor
//                decodes the serial line and pops/compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_status_uart_tx;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  state;
    logic [15:0] score;
    logic        send;
    logic        busy;
    logic        done;
    logic        uart_tx;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0] exp_bytes[$];
    int         exp_done[$];

    // Monitor state
    bit         mon_active = 1'b0;
    int         mon_cnt    = 0;
    int         start_err  = 0;
    int         stop_err   = 0;
    logic [7:0] mon_byte   = 8'h00;

    status_uart_tx #(
        .CLK_HZ (1000),
        .BAUD   (100)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .state   (state),
        .score   (score),
        .send    (send),
        .busy    (busy),
        .done    (done),
        .uart_tx (uart_tx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic push_line(input string s);
        for (int i = 0; i < s.len(); i++) exp_bytes.push_back(s[i]);
    endtask

    // Drive a one-cycle send; t is the negedge count before the sampling edge
    task automatic pulse_send(output int t);
        @(negedge clk);
        send = 1'b1;
        t    = cyc;
        @(negedge clk);
        send = 1'b0;
    endtask

    // Serial decoder and done-pulse checker, sampling on the falling edge
    always @(negedge clk) begin
        if (!reset_n) begin
            mon_active = 1'b0;
        end else begin
            if (!mon_active && (uart_tx === 1'b0)) begin
                mon_active = 1'b1;
                mon_cnt    = 0;
                start_err  = 0;
                stop_err   = 0;
                mon_byte   = 8'h00;
            end else if (mon_active) begin
                mon_cnt++;
            end
            if (mon_active) begin
                if ((mon_cnt < 10) && (uart_tx !== 1'b0)) start_err++;
                if ((mon_cnt >= 10) && (mon_cnt < 90) && ((mon_cnt % 10) == 5))
                    mon_byte[(mon_cnt - 15) / 10] = uart_tx;
                if ((mon_cnt >= 90) && (uart_tx !== 1'b1)) stop_err++;
                if (mon_cnt == 99) begin
                    check("start_bit_low", start_err, 0);
                    check("stop_bit_high", stop_err, 0);
                    if (exp_bytes.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_byte: got 0x%0h expected none (cycle %0d)", mon_byte, cyc);
                    end else begin
                        check("rx_byte", mon_byte, exp_bytes.pop_front());
                    end
                    mon_active = 1'b0;
                end
            end
            if (done === 1'b1) begin
                if (exp_done.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got pulse at cycle %0d expected none", cyc);
                end else begin
                    check("done_cycle", cyc, exp_done.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish by cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int t;
        int t0;
        int err;

        reset_n = 1'b0;
        send    = 1'b0;
        state   = 8'h00;
        score   = 16'h0000;
        repeat (3) @(negedge clk);
        check("rst_tx", uart_tx, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        reset_n = 1'b1;

        // Idle hold after reset
        err = 0;
        repeat (50) begin
            @(negedge clk);
            if ((uart_tx !== 1'b1) || (busy !== 1'b0) || (done !== 1'b0)) err++;
        end
        check("idle_hold", err, 0);

        // Basic line
        state = 8'h0A;
        score = 16'h012F;
        push_line("S0A P012F\r\n");
        check("busy_before_send", busy, 0);
        pulse_send(t);
        exp_done.push_back(t + 1101);
        check("busy_after_send", busy, 1);
        check("first_start_low", uart_tx, 0);
        repeat (1110) @(negedge clk);
        check("busy_end_line1", busy, 0);

        // Inputs change after the snapshot
        pulse_send(t);
        exp_done.push_back(t + 1101);
        push_line("S0A P012F\r\n");
        repeat (4) @(negedge clk);
        state = 8'hFF;
        score = 16'hFFFF;
        repeat (1110) @(negedge clk);

        // Sends while busy: one pending, the extra one dropped
        state = 8'h01;
        score = 16'hBEEF;
        push_line("S01 PBEEF\r\n");
        pulse_send(t0);
        exp_done.push_back(t0 + 1101);
        exp_done.push_back(t0 + 2202);
        err = 0;
        while (cyc <= t0 + 2201) begin
            if (busy !== 1'b1) err++;
            if (cyc == t0 + 300) begin
                state = 8'h02;
                send  = 1'b1;
                push_line("S02 PBEEF\r\n");
            end else if (cyc == t0 + 600) begin
                send = 1'b1;
            end else begin
                send = 1'b0;
            end
            @(negedge clk);
        end
        check("busy_continuous", err, 0);
        check("busy_second_fin", busy, 0);
        check("done_second_fin", done, 1);
        repeat (1200) @(negedge clk);
        check("no_third_line", exp_bytes.size(), 0);
        check("busy_after_pair", busy, 0);

        // Reset in the middle of byte 4 (data bit 3 of 'P' is 0)
        state = 8'h0A;
        score = 16'h012F;
        push_line("S0A P012F\r\n");
        pulse_send(t);
        exp_done.push_back(t + 1101);
        while (cyc < t + 445) @(negedge clk);
        check("pre_reset_tx", uart_tx, 0);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_tx", uart_tx, 1);
        check("async_reset_busy", busy, 0);
        repeat (3) @(negedge clk);
        exp_bytes.delete();
        exp_done.delete();
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("post_reset_tx", uart_tx, 1);
        state = 8'h5A;
        score = 16'h9C3E;
        push_line("S5A P9C3E\r\n");
        pulse_send(t);
        exp_done.push_back(t + 1101);
        repeat (1110) @(negedge clk);

        // Send on the FIN cycle
        state = 8'h33;
        score = 16'h4455;
        push_line("S33 P4455\r\n");
        pulse_send(t);
        exp_done.push_back(t + 1101);
        while (cyc < t + 1101) @(negedge clk);
        check("fin_done", done, 1);
        check("fin_tx_idle", uart_tx, 1);
        state = 8'h77;
        score = 16'h8899;
        send  = 1'b1;
        push_line("S77 P8899\r\n");
        exp_done.push_back(t + 2202);
        #1;
        check("fin_send_busy", busy, 1);
        @(negedge clk);
        send = 1'b0;
        check("line2_start_low", uart_tx, 0);
        check("line2_busy", busy, 1);
        repeat (1110) @(negedge clk);

        check("bytes_drained", exp_bytes.size(), 0);
        check("dones_drained", exp_done.size(), 0);
        check("final_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
